// File: rtl/mic1_sequencer_if.sv
// rtl/mic1_sequencer_if.sv - control-store, datapath-control and memory-handshake bundle for mic1_sequencer
interface mic1_sequencer_if;
  logic [8:0]  cs_addr;
  logic [35:0] cs_data;
  logic [15:0] mir;
  logic [7:0]  alu_ctrl;
  logic        alu_n;
  logic        alu_z;
  logic [7:0]  mbr;
  logic        mem_read;
  logic        mem_write;
  logic        mem_fetch;
  logic        mem_ready;
  logic        fetch_ready;
  logic        stall;

  modport master (
    output cs_addr, mir, alu_ctrl, mem_read, mem_write, mem_fetch, stall,
    input  cs_data, alu_n, alu_z, mbr, mem_ready, fetch_ready
  );

  modport slave (
    input  cs_addr, mir, alu_ctrl, mem_read, mem_write, mem_fetch, stall,
    output cs_data, alu_n, alu_z, mbr, mem_ready, fetch_ready
  );
endinterface

// File: rtl/mic1_sequencer.sv
// rtl/mic1_sequencer.sv - MIC-1 microprogram sequencer: MPC, next-address logic, field split and MDR/MBR hazard stall
module mic1_sequencer (
  input  logic               clock,
  input  logic               reset,
  mic1_sequencer_if.master   bus
);

  logic [8:0] mpc_q, mpc_d;
  logic       rd_pend_q, rd_pend_d;
  logic       wr_pend_q, wr_pend_d;
  logic       f_pend_q, f_pend_d;

  logic [8:0] na_f;
  logic       jmpc_f, jamn_f, jamz_f;
  logic [7:0] alu_f;
  logic [8:0] c_f;
  logic       wr_f, rd_f, fe_f;
  logic [3:0] b_f;

  assign na_f   = bus.cs_data[35:27];
  assign jmpc_f = bus.cs_data[26];
  assign jamn_f = bus.cs_data[25];
  assign jamz_f = bus.cs_data[24];
  assign alu_f  = bus.cs_data[23:16];
  assign c_f    = bus.cs_data[15:7];
  assign wr_f   = bus.cs_data[6];
  assign rd_f   = bus.cs_data[5];
  assign fe_f   = bus.cs_data[4];
  assign b_f    = bus.cs_data[3:0];

  logic       stall_c;
  logic [8:0] next_addr;

  // c_f[1] is the MDR write enable; B values 2/3 read MBR.
  always_comb begin
    stall_c = ((rd_pend_q | wr_pend_q) & (rd_f | wr_f))
            | (rd_pend_q & ((b_f == 4'd0) | c_f[1]))
            | (f_pend_q & (fe_f | (b_f == 4'd2) | (b_f == 4'd3) | jmpc_f));
  end

  always_comb begin
    next_addr[8]   = na_f[8] | (jamn_f & bus.alu_n) | (jamz_f & bus.alu_z);
    next_addr[7:0] = jmpc_f ? (na_f[7:0] | bus.mbr) : na_f[7:0];
  end

  always_comb begin
    bus.cs_addr   = mpc_q;
    bus.stall     = stall_c;
    bus.mir       = 16'h0000;
    bus.alu_ctrl  = 8'h00;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_fetch = 1'b0;

    bus.mir[3:0]  = b_f;
    bus.mir[5]    = rd_pend_q & bus.mem_ready;
    bus.mir[4]    = f_pend_q & bus.fetch_ready;

    if (!stall_c) begin
      bus.mir[15:7] = c_f;
      bus.mir[6]    = wr_f;
      bus.alu_ctrl  = alu_f;
      bus.mem_read  = rd_f;
      bus.mem_write = wr_f;
      bus.mem_fetch = fe_f;
    end
  end

  // Clears come first so a request issued in the same cycle is never lost;
  // a ready pulse with nothing pending clears flags that are already zero.
  always_comb begin
    mpc_d     = mpc_q;
    rd_pend_d = rd_pend_q;
    wr_pend_d = wr_pend_q;
    f_pend_d  = f_pend_q;

    if (bus.mem_ready) begin
      rd_pend_d = 1'b0;
      wr_pend_d = 1'b0;
    end
    if (bus.fetch_ready) begin
      f_pend_d = 1'b0;
    end

    if (!stall_c) begin
      mpc_d     = next_addr;
      rd_pend_d = rd_pend_d | rd_f;
      wr_pend_d = wr_pend_d | (wr_f & ~rd_f);
      f_pend_d  = f_pend_d | fe_f;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mpc_q     <= 9'd0;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
      f_pend_q  <= 1'b0;
    end else begin
      mpc_q     <= mpc_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      f_pend_q  <= f_pend_d;
    end
  end

endmodule

// File: tb/tb_mic1_sequencer.sv
// tb/tb_mic1_sequencer.sv - scoreboard bench for mic1_sequencer
module tb_mic1_sequencer;

  logic clock;
  logic reset;
  mic1_sequencer_if bus();

  mic1_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [35:0] rom [512];
  assign bus.cs_data = rom[bus.cs_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [8:0] addr;
    logic [15:0] mir;
    logic [7:0] alu;
    logic       stall;
    logic [2:0] strb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic [8:0] na, input logic jm, input logic jn,
                                     input logic jz, input logic [7:0] alu, input logic [8:0] c,
                                     input logic wr, input logic rd, input logic fe,
                                     input logic [3:0] b);
    return {na, jm, jn, jz, alu, c, wr, rd, fe, b};
  endfunction

  // Drive one cycle's inputs, queue what the DUT must show, then compare at the falling edge.
  task automatic cyc(input string tag, input logic z, input logic n, input logic mr,
                     input logic fr, input logic [8:0] a, input logic [15:0] m,
                     input logic [7:0] al, input logic st, input logic [2:0] s);
    exp_t e;
    bus.alu_z       = z;
    bus.alu_n       = n;
    bus.mem_ready   = mr;
    bus.fetch_ready = fr;
    sb.push_back('{tag, a, m, al, st, s});
    @(negedge clock);
    e = sb.pop_front();
    check({e.tag, ".cs_addr"}, {23'd0, bus.cs_addr}, {23'd0, e.addr});
    check({e.tag, ".mir"},     {16'd0, bus.mir},     {16'd0, e.mir});
    check({e.tag, ".alu"},     {24'd0, bus.alu_ctrl}, {24'd0, e.alu});
    check({e.tag, ".stall"},   {31'd0, bus.stall},   {31'd0, e.stall});
    check({e.tag, ".strb"},    {29'd0, bus.mem_read, bus.mem_write, bus.mem_fetch}, {29'd0, e.strb});
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    bus.alu_n       = 1'b0;
    bus.alu_z       = 1'b0;
    bus.mbr         = 8'h3C;
    bus.mem_ready   = 1'b0;
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 512; i++) rom[i] = 36'd0;

    rom[9'h000] = mk(9'h005, 0, 0, 0, 8'h3C, 9'h100, 0, 0, 0, 4'd1);
    rom[9'h005] = mk(9'h012, 0, 0, 1, 8'hA5, 9'h000, 0, 0, 0, 4'd0);
    rom[9'h112] = mk(9'h005, 0, 0, 0, 8'h00, 9'h000, 0, 0, 0, 4'd0);
    rom[9'h012] = mk(9'h020, 0, 0, 0, 8'h00, 9'h000, 0, 0, 0, 4'd0);
    rom[9'h020] = mk(9'h030, 0, 1, 0, 8'h00, 9'h000, 0, 0, 0, 4'd0);
    rom[9'h130] = mk(9'h020, 0, 0, 0, 8'h00, 9'h000, 0, 0, 0, 4'd0);
    rom[9'h030] = mk(9'h100, 1, 0, 0, 8'h00, 9'h000, 0, 0, 0, 4'd0);
    rom[9'h13C] = mk(9'h041, 0, 0, 0, 8'h00, 9'h000, 0, 0, 1, 4'd0);
    rom[9'h041] = mk(9'h100, 1, 0, 0, 8'h00, 9'h000, 0, 0, 0, 4'd0);
    rom[9'h050] = mk(9'h051, 0, 0, 0, 8'h00, 9'h000, 0, 1, 0, 4'd4);
    rom[9'h051] = mk(9'h052, 0, 0, 0, 8'h00, 9'h100, 0, 0, 0, 4'd0);
    rom[9'h052] = mk(9'h053, 0, 0, 0, 8'h00, 9'h000, 0, 1, 1, 4'd1);
    rom[9'h053] = mk(9'h054, 0, 0, 0, 8'h00, 9'h008, 0, 0, 0, 4'd4);
    rom[9'h054] = mk(9'h055, 0, 0, 0, 8'h00, 9'h000, 0, 0, 0, 4'd5);
    rom[9'h055] = mk(9'h056, 0, 0, 0, 8'h00, 9'h000, 1, 0, 0, 4'd1);
    rom[9'h056] = mk(9'h058, 0, 0, 0, 8'h00, 9'h000, 0, 1, 0, 4'd2);
    rom[9'h058] = mk(9'h058, 0, 0, 0, 8'h00, 9'h000, 0, 0, 0, 4'd0);

    //          tag         z  n  mr fr addr     mir       alu    st strb
    cyc("reset",            0, 0, 0, 0, 9'h000, 16'h8001, 8'h3C, 0, 3'b000);
    reset = 1'b0;
    cyc("word0",            0, 0, 0, 0, 9'h000, 16'h8001, 8'h3C, 0, 3'b000);
    cyc("jamz_z1",          1, 0, 0, 0, 9'h005, 16'h0000, 8'hA5, 0, 3'b000);
    cyc("after_z1",         0, 0, 0, 0, 9'h112, 16'h0000, 8'h00, 0, 3'b000);
    cyc("jamz_z0",          0, 0, 0, 0, 9'h005, 16'h0000, 8'hA5, 0, 3'b000);
    cyc("after_z0",         0, 0, 0, 0, 9'h012, 16'h0000, 8'h00, 0, 3'b000);
    cyc("jamn_n1",          0, 1, 0, 0, 9'h020, 16'h0000, 8'h00, 0, 3'b000);
    cyc("after_n1",         0, 0, 0, 0, 9'h130, 16'h0000, 8'h00, 0, 3'b000);
    cyc("jamn_n0",          0, 0, 0, 0, 9'h020, 16'h0000, 8'h00, 0, 3'b000);
    cyc("jmpc",             0, 0, 0, 0, 9'h030, 16'h0000, 8'h00, 0, 3'b000);
    cyc("fetch_req",        0, 0, 0, 1, 9'h13C, 16'h0000, 8'h00, 0, 3'b001);
    rom[9'h13C] = mk(9'h050, 0, 0, 0, 8'h00, 9'h000, 0, 0, 0, 4'd0);
    cyc("jmpc_wait",        0, 0, 0, 0, 9'h041, 16'h0000, 8'h00, 1, 3'b000);
    cyc("jmpc_fready",      0, 0, 0, 1, 9'h041, 16'h0010, 8'h00, 1, 3'b000);
    cyc("jmpc_exec",        0, 0, 0, 0, 9'h041, 16'h0000, 8'h00, 0, 3'b000);
    cyc("jmpc_target",      0, 0, 0, 0, 9'h13C, 16'h0000, 8'h00, 0, 3'b000);
    cyc("read_req",         0, 0, 1, 0, 9'h050, 16'h0004, 8'h00, 0, 3'b100);
    cyc("rd_stall1",        0, 0, 0, 0, 9'h051, 16'h0000, 8'h00, 1, 3'b000);
    cyc("rd_stall2",        0, 0, 0, 0, 9'h051, 16'h0000, 8'h00, 1, 3'b000);
    cyc("rd_ready",         0, 0, 1, 0, 9'h051, 16'h0020, 8'h00, 1, 3'b000);
    cyc("rd_consume",       0, 0, 0, 0, 9'h051, 16'h8000, 8'h00, 0, 3'b000);
    cyc("rdfe_req",         0, 0, 0, 0, 9'h052, 16'h0001, 8'h00, 0, 3'b101);
    cyc("sp_fready",        0, 0, 0, 1, 9'h053, 16'h0414, 8'h00, 0, 3'b000);
    cyc("lv_mready",        0, 0, 1, 0, 9'h054, 16'h0025, 8'h00, 0, 3'b000);
    cyc("write_req",        0, 0, 0, 0, 9'h055, 16'h0041, 8'h00, 0, 3'b010);
    cyc("rd_after_wr",      0, 0, 0, 0, 9'h056, 16'h0002, 8'h00, 1, 3'b000);
    cyc("wr_ready",         0, 0, 1, 0, 9'h056, 16'h0002, 8'h00, 1, 3'b000);
    cyc("rd_issue",         0, 0, 0, 0, 9'h056, 16'h0002, 8'h00, 0, 3'b100);
    cyc("mdr_wait",         0, 0, 0, 0, 9'h058, 16'h0000, 8'h00, 1, 3'b000);
    reset = 1'b1;
    cyc("mid_reset",        0, 0, 0, 0, 9'h000, 16'h8001, 8'h3C, 0, 3'b000);
    reset = 1'b0;
    cyc("late_ready",       0, 0, 1, 0, 9'h000, 16'h8001, 8'h3C, 0, 3'b000);
    cyc("post_reset",       0, 0, 0, 0, 9'h005, 16'h0000, 8'hA5, 0, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic1_sequencer.md
# mic1_sequencer

Microprogram sequencer for the MIC-1 datapath. It holds MPC, addresses the external control store, and splits each 36-bit microinstruction into the 16-bit datapath control word, the ALU/shifter controls and the memory request strobes. It computes the next MPC from NEXT_ADDRESS, JAMN, JAMZ and JMPC. It tracks outstanding data-port and fetch-port memory operations and stalls the microprogram on MDR/MBR hazards. It sits between the control store, the register/bus datapath, the ALU and the memory interface.

## Interface
- No parameters; all widths fixed.
- clock  in  1  rising-edge clock, same net as the datapath.
- reset  in  1  asynchronous, active-high.
- cs_addr  out  9  control-store address; equals MPC.
- cs_data  in  36  microinstruction, asynchronous read of cs_addr. Fields:
  - NEXT_ADDRESS[35:27], JMPC[26], JAMN[25], JAMZ[24]
  - SLL8[23], SRA1[22], F0[21], F1[20], ENA[19], ENB[18], INVA[17], INC[16]
  - C[15:7] (H,OPC,TOS,CPP,LV,SP,PC,MDR,MAR)
  - WRITE[6], READ[5], FETCH[4], B[3:0]
- mir  out  16  datapath control word: [15:7] C enables, [6] write, [5] MDR-load-from-RAM, [4] MBR-load-from-ROM, [3:0] B select.
- alu_ctrl  out  8  {SLL8,SRA1,F0,F1,ENA,ENB,INVA,INC}.
- alu_n, alu_z  in  1  ALU flags of the current cycle.
- mbr  in  8  datapath MBR low byte, used by JMPC.
- mem_read, mem_write  out  1  data-port request strobes, one cycle each.
- mem_fetch  out  1  instruction-port request strobe, one cycle.
- mem_ready  in  1  one-cycle pulse: the pending data-port op has completed (read data valid on RAM_data this cycle).
- fetch_ready  in  1  one-cycle pulse: the pending fetch has completed (ROM_data valid this cycle).
- stall  out  1  high in every cycle the current microinstruction is held.

## Operation
- State:
  - mpc[8:0]
  - rd_pend and wr_pend (mutually exclusive)
  - f_pend
- Hazard; stall is combinational from cs_data and the pending flags. stall = any of:
  - (rd_pend|wr_pend) & (READ|WRITE)
  - rd_pend & (B==0 | C.MDR)
  - f_pend & (FETCH | B==2 | B==3 | JMPC)
- Non-stall cycle:
  - mir[15:7] = C; mir[6] = WRITE; mir[3:0] = B; alu_ctrl driven from the fields.
  - mem_read = READ; mem_write = WRITE; mem_fetch = FETCH.
  - At the edge: mpc <= next; rd_pend |= READ; wr_pend |= WRITE; f_pend |= FETCH.
- Stall cycle:
  - mir[15:6] = 0; mir[3:0] = B; alu_ctrl = 0; no requests.
  - mpc held.
- Load strobes, independent of stall:
  - mir[5] = rd_pend & mem_ready
  - mir[4] = f_pend & fetch_ready
- Pending clears:
  - rd_pend/wr_pend clear at the edge of the mem_ready cycle.
  - f_pend clears at the edge of the fetch_ready cycle.
- Next-address rule, 9-bit, no carry:
  - next[8] = NA[8] | (JAMN & alu_n) | (JAMZ & alu_z)
  - next[7:0] = JMPC ? (NA[7:0] | mbr) : NA[7:0]
- READ+FETCH in one microinstruction is legal (separate ports). READ+WRITE together is illegal microcode; behaviour is unspecified but must not deadlock.
- mem_ready with no data op pending, or fetch_ready with no fetch pending, is ignored.

## Timing
- Reset values:
  - mpc = 0, all pending flags = 0.
  - cs_addr = 0.
  - mir, alu_ctrl and strobes follow the word at address 0 with no hazard.
- Reset mid-operation: pending flags are dropped. A late ready pulse after reset produces no load strobe.
- One microinstruction per cycle when not stalled. cs_addr changes only on clock edges.
- Requests are asserted in the execute cycle of the issuing microinstruction.
- A ready pulse is accepted no earlier than the following cycle; a ready pulse in the request cycle is ignored.
- Minimum read-to-use: the request cycle, then the ready cycle (stalled if it uses MDR), then the consumer executes. In the ready cycle the stall holds because the pending flag is still set.
- Consumer timing:
  - A microinstruction with B==0 waits for the MDR loaded at the end of the mem_ready cycle.
  - A microinstruction with JMPC waits for the fetch_ready cycle + 1.
- A non-hazard microinstruction executes in parallel with an outstanding op; it may load MAR/PC freely.
- Simultaneous mem_ready and fetch_ready both produce their load strobes in the same cycle.

## Test plan
- Reset with word@0 = NA 0x005, C = H, B = 1 -> cs_addr=0, mir=16'h8001, stall=0. After 1 clock, cs_addr=0x005.
- JAMZ word with NA=0x012: alu_z=1 -> next cs_addr=0x112; alu_z=0 -> 0x012. JAMN with alu_n=1 gives the same results.
- JMPC word with NA=0x100, mbr=0x3C -> cs_addr=0x13C. With f_pend set -> stall=1 until fetch_ready, then cs_addr=0x13C.
- READ word, then B=0 word; mem_ready 3 cycles after the request:
  - mem_read high exactly 1 cycle.
  - stall=1 for 3 cycles; mir[5]=1 in the 3rd.
  - The consumer executes the next cycle.
- READ+FETCH word, fetch_ready after 1 cycle, mem_ready after 2 cycles -> mir[4] and mir[5] each pulse once. An intervening microinstruction with B=4 (SP) executes without stall.
- Assert reset with rd_pend set, deassert, then pulse mem_ready -> mir[5] stays 0, cs_addr=0, no stall.
